// File: rtl/dvp_pattern_tx.sv
// Synthetic OV7670-style DVP source: pclk = clk/2, vsync/href/data change on pclk falls.
// Optional macro DVP_TX_INC_PATTERN_EN adds the incrementing pattern on pattern_sel=1.
`timescale 1ns/1ps
module dvp_pattern_tx #(
    parameter int H_ACTIVE    = 40,
    parameter int V_ACTIVE    = 30,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb565,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_dat,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
    } state_t;

    localparam logic [11:0] HA_TC  = 12'(2 * H_ACTIVE - 1);
    localparam logic [11:0] HB_TC  = 12'(H_BLANK - 1);
    localparam logic [11:0] VS_TC  = 12'(VSYNC_LINES - 1);
    localparam logic [11:0] VB_TC  = 12'(V_BACK - 1);
    localparam logic [11:0] VA_TC  = 12'(V_ACTIVE - 1);
    localparam logic [11:0] VF_TC  = 12'(V_FRONT - 1);
    localparam logic [11:0] BAR_TC = 12'(H_ACTIVE / 8 - 1);

    state_t      state_q, state_d;
    logic        ph_q;
    logic        hb_q, hb_d;          // 1 while in the horizontal blank part of a line
    logic [11:0] hcnt_q, hcnt_d;      // byte index (active part) or blank tick index
    logic [11:0] line_q, line_d;      // line index within the current state
    logic [2:0]  bar_q, bar_d;
    logic [11:0] barpx_q, barpx_d;
    logic [1:0]  pat_q;
    logic [15:0] solid_q;
    logic        vsync_q, href_q, done_q;
    logic [7:0]  dat_q;
    logic [15:0] fcnt_q;

    logic        line_end, latch, done_d, href_d, vsync_d;
    logic [11:0] line_tc;
    logic [15:0] pix;
    logic [7:0]  byte_sel, dat_d;

    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    endfunction

    always_comb begin
        case (state_q)
            S_VSYNC:  line_tc = VS_TC;
            S_VBACK:  line_tc = VB_TC;
            S_ACTIVE: line_tc = VA_TC;
            default:  line_tc = VF_TC;
        endcase
    end

    // Next position/state; outputs are registered from these next values so
    // they appear on the very tick that enters a position.
    always_comb begin
        state_d  = state_q;
        hb_d     = hb_q;
        hcnt_d   = hcnt_q;
        line_d   = line_q;
        bar_d    = bar_q;
        barpx_d  = barpx_q;
        done_d   = 1'b0;
        latch    = 1'b0;
        line_end = hb_q && (hcnt_q == HB_TC);

        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSYNC;
                hb_d    = 1'b0;
                hcnt_d  = 12'd0;
                line_d  = 12'd0;
                latch   = 1'b1;
            end
        end else begin
            if (!hb_q && (hcnt_q == HA_TC)) begin
                hb_d   = 1'b1;
                hcnt_d = 12'd0;
            end else if (line_end) begin
                hb_d   = 1'b0;
                hcnt_d = 12'd0;
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end

            if (line_end) begin
                if (line_q == line_tc) begin
                    line_d = 12'd0;
                    case (state_q)
                        S_VSYNC:  state_d = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
                        S_VBACK:  state_d = S_ACTIVE;
                        S_ACTIVE: begin
                            state_d = (V_FRONT == 0) ? S_IDLE : S_VFRONT;
                            done_d  = (V_FRONT == 0);
                        end
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    line_d = line_q + 12'd1;
                end
            end
        end

        // Bar tracking: advance on the first byte of each new pixel.
        if ((state_d == S_ACTIVE) && !hb_d) begin
            if (hcnt_d == 12'd0) begin
                bar_d   = 3'd0;
                barpx_d = 12'd0;
            end else if (!hcnt_d[0]) begin
                if (barpx_q == BAR_TC) begin
                    bar_d   = bar_q + 3'd1;
                    barpx_d = 12'd0;
                end else begin
                    barpx_d = barpx_q + 12'd1;
                end
            end
        end
    end

    always_comb begin
        pix = solid_q;
        if (pat_q == 2'd0) pix = bar_rgb(bar_d);
        byte_sel = hcnt_d[0] ? pix[7:0] : pix[15:8];
`ifdef DVP_TX_INC_PATTERN_EN
        if (pat_q == 2'd1) byte_sel = hcnt_d[7:0] + line_d[7:0];
`endif
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && !hb_d;
        dat_d   = href_d ? byte_sel : 8'h00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q    <= 1'b0;
            state_q <= S_IDLE;
            hb_q    <= 1'b0;
            hcnt_q  <= 12'd0;
            line_q  <= 12'd0;
            bar_q   <= 3'd0;
            barpx_q <= 12'd0;
            pat_q   <= 2'd0;
            solid_q <= 16'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            dat_q   <= 8'd0;
            done_q  <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            ph_q   <= ~ph_q;
            done_q <= 1'b0;
            if (ph_q) begin
                state_q <= state_d;
                hb_q    <= hb_d;
                hcnt_q  <= hcnt_d;
                line_q  <= line_d;
                bar_q   <= bar_d;
                barpx_q <= barpx_d;
                vsync_q <= vsync_d;
                href_q  <= href_d;
                dat_q   <= dat_d;
                done_q  <= done_d;
                if (latch) begin
                    pat_q   <= pattern_sel;
                    solid_q <= solid_rgb565;
                end
                if (done_d) fcnt_q <= fcnt_q + 16'd1;
            end
        end
    end

    assign cam_pclk    = ph_q;
    assign cam_vsync   = vsync_q;
    assign cam_href    = href_q;
    assign cam_dat     = dat_q;
    assign frame_done  = done_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Directed bench for dvp_pattern_tx: small frame geometry, table of per-pattern line contents.
`timescale 1ns/1ps
module tb_dvp_pattern_tx;

    logic        clk = 1'b0;
    logic        reset_n, enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_rgb565;
    logic        cam_pclk, cam_vsync, cam_href, frame_done;
    logic [7:0]  cam_dat;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    dvp_pattern_tx #(
        .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb565(solid_rgb565),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_dat(cam_dat), .frame_done(frame_done), .frame_count(frame_count)
    );

    typedef struct {
        logic [1:0]   sel;
        logic [15:0]  solid;
        logic [127:0] l0;   // 16 bytes, first byte in [127:120]
        logic [127:0] l1;
    } vec_t;

    vec_t vec [6];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string nm, input logic [807:0] a, input logic [807:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", nm, a, e);
        end
    endtask

    // Advance to the next pclk fall and land 1 ns after it.
    task automatic tick(output bit ok);
        logic p;
        ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p = cam_pclk;
            @(posedge clk); #1;
            if (p && !cam_pclk) begin
                ok = 1'b1;
                return;
            end
        end
        checks++; fails++;
        $display("FAIL tick_timeout act=no_pclk_fall exp=pclk_fall");
    endtask

    task automatic run_frame(input vec_t v, input bit drop, output int lat);
        logic [100:0] evs, avs, ehr, ahr, edn, adn;
        logic [807:0] edat, adat;
        bit ok, in0, in1;
        lat = -1;
        for (int w = 1; w <= 400; w++) begin
            tick(ok);
            if (!ok) return;
            if (cam_vsync) begin
                lat = w;
                break;
            end
        end
        if (lat < 0) begin
            checks++; fails++;
            $display("FAIL vsync_wait act=timeout exp=vsync_rise");
            return;
        end
        for (int t = 0; t <= 100; t++) begin
            if (t > 0) begin
                tick(ok);
                if (!ok) return;
            end
            avs[t] = cam_vsync;
            ahr[t] = cam_href;
            adn[t] = frame_done;
            adat[807-8*t -: 8] = cam_dat;
            if (t == 50) begin
                pattern_sel  = ~v.sel;
                solid_rgb565 = ~v.solid;
                if (drop) enable = 1'b0;
            end
        end
        for (int t = 0; t <= 100; t++) begin
            in0    = (t >= 40) && (t < 56);
            in1    = (t >= 60) && (t < 76);
            evs[t] = (t < 20);
            ehr[t] = in0 || in1;
            edn[t] = (t == 100);
            edat[807-8*t -: 8] = in0 ? v.l0[127-8*(t-40) -: 8] :
                                 in1 ? v.l1[127-8*(t-60) -: 8] : 8'h00;
        end
        chk("vsync_wave", 808'(avs), 808'(evs));
        chk("href_wave", 808'(ahr), 808'(ehr));
        chk("dat_stream", adat, edat);
        chk("done_wave", 808'(adn), 808'(edn));
        @(posedge clk); #1;
        chk("done_width", 808'(frame_done), 808'(0));
        pattern_sel  = v.sel;
        solid_rgb565 = v.solid;
    endtask

    // Outputs must have been stable for a full clk before every pclk rise.
    time last_chg = 0;
    time trise;
    always @(cam_vsync or cam_href or cam_dat) last_chg = $time;
    always @(posedge cam_pclk) begin
        trise = $time;
        #1;
        checks++;
        if (last_chg + 10 > trise) begin
            fails++;
            $display("FAIL pclk_setup act=chg@%0t exp=before@%0t", last_chg, trise - 10);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ok, found;
        logic stuck;

        vec[0] = '{2'd2, 16'hA55A, {8{16'hA55A}}, {8{16'hA55A}}};
        vec[1] = '{2'd0, 16'h1234, 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000,
                                   128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000};
`ifdef DVP_TX_INC_PATTERN_EN
        vec[2] = '{2'd1, 16'h0F0F, 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F,
                                   128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10};
`else
        vec[2] = '{2'd1, 16'h0F0F, {8{16'h0F0F}}, {8{16'h0F0F}}};
`endif
        vec[3] = '{2'd3, 16'h8001, {8{16'h8001}}, {8{16'h8001}}};
        vec[4] = vec[1];
        vec[5] = '{2'd2, 16'hC33C, {8{16'hC33C}}, {8{16'hC33C}}};

        reset_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_rgb565 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 808'({cam_pclk, cam_vsync, cam_href, cam_dat, frame_done, frame_count}), 808'(0));

        enable = 1'b1; pattern_sel = vec[0].sel; solid_rgb565 = vec[0].solid;
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back frames, one pattern per frame.
        for (int i = 0; i < 4; i++) begin
            pattern_sel  = vec[i].sel;
            solid_rgb565 = vec[i].solid;
            run_frame(vec[i], 1'b0, lat);
            chk($sformatf("start_lat%0d", i), 808'(lat), 808'(1));
            chk($sformatf("frame_count%0d", i), 808'(frame_count), 808'(i + 1));
        end

        // Drop enable mid-line: frame finishes, then stays idle.
        pattern_sel = vec[4].sel; solid_rgb565 = vec[4].solid;
        run_frame(vec[4], 1'b1, lat);
        chk("start_lat_drop", 808'(lat), 808'(1));
        chk("frame_count_drop", 808'(frame_count), 808'(5));
        stuck = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick(ok);
            if (!ok) break;
            stuck = stuck | cam_vsync | cam_href | (cam_dat != 8'h00) | frame_done;
        end
        chk("idle_quiet", 808'(stuck), 808'(0));
        chk("idle_count", 808'(frame_count), 808'(5));

        // Async reset in the middle of an active line.
        enable = 1'b1; pattern_sel = 2'd0;
        found = 1'b0;
        for (int w = 0; w < 300; w++) begin
            tick(ok);
            if (!ok) break;
            if (cam_href) begin
                found = 1'b1;
                break;
            end
        end
        chk("href_seen", 808'(found), 808'(1));
        repeat (3) tick(ok);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 808'({cam_pclk, cam_vsync, cam_href, cam_dat, frame_done, frame_count}), 808'(0));
        repeat (2) @(posedge clk);
        pattern_sel = vec[5].sel; solid_rgb565 = vec[5].solid;
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(vec[5], 1'b0, lat);
        chk("start_lat_rst", 808'(lat), 808'(1));
        chk("frame_count_rst", 808'(frame_count), 808'(1));
        enable = 1'b0;

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
